accum_window_ctrl: RTL and testbench

Windowed lookup-and-accumulate controller for the integrator datapath. Accepts 4-bit sample codes over a valid/ready handshake and maps each through the fixed 16-entry weight table (entry i = 25·i, 9 bits). It sums WINDOW weighted samples into a 13-bit accumulator, then presents the total on a valid/ready result port. The FSM takes over the ripple-counter sequencing of the existing integrator: windows are counted explicitly, the accumulator is cleared synchronously, and back-pressure is handled on both sides.

---
 rtl/accum_window_ctrl.sv | 82 ++++++++
 tb/tb_accum_window_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/accum_window_ctrl.sv
// Windowed lookup-and-accumulate controller: maps 4-bit codes through a fixed
// 25*x weight table, sums WINDOW samples and hands the total out over valid/ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_ACCUM  | accepting samples, sum shows the running partial total
// S_RESULT | window closed, total held on sum until out_ready is seen
module accum_window_ctrl #(
  parameter int WINDOW = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  x,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] sum,
  output logic [4:0]  sample_count
);

  typedef enum logic {
    S_ACCUM  = 1'b0,
    S_RESULT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [8:0]  weight;
  logic        accept;

  assign weight = {5'b0, x} * 9'd25;

  // Handshake outputs decode the registered state only.
  assign in_ready     = (state_q == S_ACCUM);
  assign out_valid    = (state_q == S_RESULT);
  assign accept       = in_valid && in_ready;
  assign sum          = acc_q;
  assign sample_count = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_ACCUM: begin
        if (accept) begin
          acc_d = acc_q + {4'b0, weight};
          cnt_d = cnt_q + 5'd1;
        end
        // cnt_d already includes a same-cycle accept, so a flush alone on an
        // empty window never produces a result.
        if ((cnt_d == 5'(WINDOW)) || (flush && (cnt_d != 5'd0))) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (out_ready) begin
          acc_d   = 13'd0;
          cnt_d   = 5'd0;
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_ACCUM;
      acc_q   <= 13'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_accum_window_ctrl.sv
// Self-checking bench for accum_window_ctrl: three instances (WINDOW=4,16,1)
// share stimulus and are compared against a per-window reference model.
module tb_accum_window_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  x;
  logic        flush;
  logic        out_ready;
  logic        ir_o [3];
  logic        ov_o [3];
  logic [12:0] sum_o [3];
  logic [4:0]  cnt_o [3];

  int checks = 0;
  int failures = 0;

  // Reference model: window length, running total, count, result pending.
  int win [3] = '{4, 16, 1};
  int m_acc [3];
  int m_cnt [3];
  bit m_pend [3];

  always #5 clock = ~clock;

  accum_window_ctrl #(.WINDOW(4)) u_w4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_o[0]), .x(x),
    .flush(flush), .out_valid(ov_o[0]), .out_ready(out_ready), .sum(sum_o[0]),
    .sample_count(cnt_o[0]));
  accum_window_ctrl #(.WINDOW(16)) u_w16 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_o[1]), .x(x),
    .flush(flush), .out_valid(ov_o[1]), .out_ready(out_ready), .sum(sum_o[1]),
    .sample_count(cnt_o[1]));
  accum_window_ctrl #(.WINDOW(1)) u_w1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir_o[2]), .x(x),
    .flush(flush), .out_valid(ov_o[2]), .out_ready(out_ready), .sum(sum_o[2]),
    .sample_count(cnt_o[2]));

  // Drive one cycle of inputs, advance the model across the edge, settle #1 after it.
  task automatic step(input bit rs, input bit iv, input int xv, input bit fl, input bit ordy);
    reset = rs; in_valid = iv; x = 4'(xv); flush = fl; out_ready = ordy;
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      if (rs) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
      end else if (m_pend[i]) begin
        if (ordy) begin
          m_acc[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
        end
      end else begin
        if (iv) begin
          m_acc[i] += 25 * xv;
          m_cnt[i] += 1;
        end
        if (m_cnt[i] == win[i] || (fl && m_cnt[i] > 0)) m_pend[i] = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ir_o[i] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, ir_o[i]); end
      checks++; if (ov_o[i] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, ov_o[i]); end
      checks++; if (sum_o[i] !== 13'd0) begin failures++; $display("FAIL reset_sum[%0d] got=%0d exp=0", i, sum_o[i]); end
      checks++; if (cnt_o[i] !== 5'd0) begin failures++; $display("FAIL reset_count[%0d] got=%0d exp=0", i, cnt_o[i]); end
    end
  endtask

  task automatic test_basic_window;
    int xs [4] = '{10, 5, 12, 1};
    int exp_sum [4] = '{250, 375, 675, 700};
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, xs[k], 0, 1);
      checks++; if (sum_o[0] !== 13'(exp_sum[k])) begin failures++; $display("FAIL basic_sum[%0d] got=%0d exp=%0d", k, sum_o[0], exp_sum[k]); end
      checks++; if (ov_o[0] !== (k == 3)) begin failures++; $display("FAIL basic_out_valid[%0d] got=%b exp=%b", k, ov_o[0], k == 3); end
    end
    checks++; if (cnt_o[0] !== 5'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", cnt_o[0]); end
    step(0, 0, 0, 0, 1);
    checks++; if (ov_o[0] !== 1'b0) begin failures++; $display("FAIL basic_ov_after got=%b exp=0", ov_o[0]); end
    checks++; if (sum_o[0] !== 13'd0) begin failures++; $display("FAIL basic_sum_after got=%0d exp=0", sum_o[0]); end
    checks++; if (cnt_o[0] !== 5'd0) begin failures++; $display("FAIL basic_count_after got=%0d exp=0", cnt_o[0]); end
    checks++; if (ir_o[0] !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", ir_o[0]); end
  endtask

  task automatic test_backpressure;
    int xs [4] = '{10, 5, 12, 1};
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, xs[k], 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 15, 0, 0);
      checks++; if (sum_o[0] !== 13'd700) begin failures++; $display("FAIL bp_sum[%0d] got=%0d exp=700", k, sum_o[0]); end
      checks++; if (ir_o[0] !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, ir_o[0]); end
      checks++; if (ov_o[0] !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", k, ov_o[0]); end
      checks++; if (cnt_o[0] !== 5'd4) begin failures++; $display("FAIL bp_count[%0d] got=%0d exp=4", k, cnt_o[0]); end
    end
    step(0, 1, 15, 0, 1);
    checks++; if (sum_o[0] !== 13'd0 || cnt_o[0] !== 5'd0) begin failures++; $display("FAIL bp_restart sum=%0d cnt=%0d exp sum=0 cnt=0", sum_o[0], cnt_o[0]); end
    step(0, 1, 15, 0, 1);
    checks++; if (sum_o[0] !== 13'd375 || cnt_o[0] !== 5'd1) begin failures++; $display("FAIL bp_next sum=%0d cnt=%0d exp sum=375 cnt=1", sum_o[0], cnt_o[0]); end
  endtask

  task automatic test_flush;
    step(1, 0, 0, 0, 0);
    step(0, 1, 13, 0, 0);
    step(0, 1, 7, 1, 0);
    checks++; if (ov_o[0] !== 1'b1) begin failures++; $display("FAIL flush_out_valid got=%b exp=1", ov_o[0]); end
    checks++; if (sum_o[0] !== 13'd500) begin failures++; $display("FAIL flush_sum got=%0d exp=500", sum_o[0]); end
    checks++; if (cnt_o[0] !== 5'd2) begin failures++; $display("FAIL flush_count got=%0d exp=2", cnt_o[0]); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    checks++; if (ov_o[0] !== 1'b0) begin failures++; $display("FAIL flush_empty_ov got=%b exp=0", ov_o[0]); end
    checks++; if (ir_o[0] !== 1'b1 || cnt_o[0] !== 5'd0 || sum_o[0] !== 13'd0) begin
      failures++; $display("FAIL flush_empty_state ir=%b cnt=%0d sum=%0d exp ir=1 cnt=0 sum=0", ir_o[0], cnt_o[0], sum_o[0]);
    end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 0, 0, 1);
    step(0, 1, 9, 0, 1);
    step(0, 1, 2, 0, 1);
    checks++; if (sum_o[0] !== 13'd275) begin failures++; $display("FAIL rmid_partial got=%0d exp=275", sum_o[0]); end
    step(1, 1, 3, 0, 1);
    checks++; if (sum_o[0] !== 13'd0 || cnt_o[0] !== 5'd0 || ov_o[0] !== 1'b0) begin
      failures++; $display("FAIL rmid_cleared sum=%0d cnt=%0d ov=%b exp 0/0/0", sum_o[0], cnt_o[0], ov_o[0]);
    end
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0);
    checks++; if (ov_o[0] !== 1'b1 || sum_o[0] !== 13'd100) begin
      failures++; $display("FAIL rmid_window ov=%b sum=%0d exp ov=1 sum=100", ov_o[0], sum_o[0]);
    end
  endtask

  task automatic test_boundary;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) step(0, 1, 15, 0, 0);
    checks++; if (ov_o[1] !== 1'b0 || sum_o[1] !== 13'd5625) begin
      failures++; $display("FAIL w16_before ov=%b sum=%0d exp ov=0 sum=5625", ov_o[1], sum_o[1]);
    end
    step(0, 1, 15, 0, 0);
    checks++; if (ov_o[1] !== 1'b1 || sum_o[1] !== 13'h1770 || cnt_o[1] !== 5'd16) begin
      failures++; $display("FAIL w16_full ov=%b sum=%0d cnt=%0d exp ov=1 sum=6000 cnt=16", ov_o[1], sum_o[1], cnt_o[1]);
    end
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    checks++; if (ov_o[2] !== 1'b1 || sum_o[2] !== 13'd0 || cnt_o[2] !== 5'd1) begin
      failures++; $display("FAIL w1_zero ov=%b sum=%0d cnt=%0d exp ov=1 sum=0 cnt=1", ov_o[2], sum_o[2], cnt_o[2]);
    end
    step(0, 0, 0, 0, 1);
    step(0, 1, 15, 0, 1);
    checks++; if (ov_o[2] !== 1'b1 || sum_o[2] !== 13'd375) begin
      failures++; $display("FAIL w1_max ov=%b sum=%0d exp ov=1 sum=375", ov_o[2], sum_o[2]);
    end
  endtask

  task automatic test_random;
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 15),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ov_o[i] !== m_pend[i] || ir_o[i] !== !m_pend[i] ||
            sum_o[i] !== 13'(m_acc[i]) || cnt_o[i] !== 5'(m_cnt[i])) begin
          failures++;
          $display("FAIL random[%0d] inst=%0d ov=%b ir=%b sum=%0d cnt=%0d exp ov=%b ir=%b sum=%0d cnt=%0d",
                   n, i, ov_o[i], ir_o[i], sum_o[i], cnt_o[i], m_pend[i], !m_pend[i], m_acc[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; x = 4'd0; flush = 1'b0; out_ready = 1'b0;
    test_reset;
    test_basic_window;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_boundary;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
